adxl362_sample_fifo: RTL and testbench
======================================

Name: adxl362_sample_fifo

Overview:
- Parametrised, single-clock successor to the ADXL362 behavioural sample FIFO used by the PmodACL2 model.
- Buffers accelerometer sample bytes written by the sensor model and drained by the SPI FIFO-read path.
- Adds configurable width and depth, a fill count, a watermark flag, and ADXL362 FIFO modes (disabled, oldest-saved, stream).
- Adds overrun detection and synchronous flush.

Parameters:
DATA_WIDTH, 8, bits per FIFO entry
DEPTH, 512, number of entries; must be a power of two, at least 2
ADDR_WIDTH, 9, pointer width; must equal log2(DEPTH)

Ports:
clk  input  1  single clock; all state changes on rising edge
reset  input  1  asynchronous, active-high reset
fifo_mode  input  2  00 disabled, 01 oldest-saved, 10 stream, 11 reserved (treated as disabled)
flush  input  1  synchronous clear of contents and overrun flag
write  input  1  write strobe, sampled each clock
data_wr  input  DATA_WIDTH  write data
read  input  1  read/pop strobe, sampled each clock
data_rd  output  DATA_WIDTH  head-of-FIFO data (show-ahead)
watermark  input  ADDR_WIDTH+1  watermark threshold; 0 disables the flag
fifo_count  output  ADDR_WIDTH+1  entries held, 0..DEPTH
fifo_empty  output  1  count == 0
fifo_full  output  1  count == DEPTH
fifo_watermark  output  1  watermark != 0 and count >= watermark
fifo_overrun  output  1  sticky; a write hit a full FIFO

Behaviour:
- Reset (asynchronous, active-high, effective immediately):
  - rd_ptr = wr_ptr = count = 0.
  - fifo_empty = 1; fifo_full, fifo_watermark, fifo_overrun = 0; data_rd = 0.
  - Memory contents are not reset.
- State: rd_ptr, wr_ptr (ADDR_WIDTH bits, natural wrap DEPTH-1 -> 0), count (ADDR_WIDTH+1 bits), overrun.
- Status flags are combinational from count and watermark; no extra latency.
- data_rd:
  - Equals mem[rd_ptr] whenever count != 0; 0 when empty.
  - A written entry is visible on data_rd the cycle after the write edge if the FIFO was empty.
- Priority per edge:
  - reset > flush/disabled > read/write.
  - Flush, or fifo_mode in {00, 11}: pointers and count cleared, overrun cleared; concurrent read/write ignored.
  - Disabled mode holds this cleared state every cycle.
- Read (modes 01/10):
  - If count != 0: rd_ptr++ and count--.
  - If empty: ignored; no pointer change and no error flag.
- Write (modes 01/10), count < DEPTH: mem[wr_ptr] = data_wr, wr_ptr++, count++.
- Write when full, oldest-saved (01): data dropped, no pointer or count change, overrun set.
- Write when full, stream (10): mem[wr_ptr] = data_wr; wr_ptr++ and rd_ptr++ (oldest discarded); count stays DEPTH; overrun set.
- Simultaneous read and write:
  - Count between 1 and DEPTH-1: both performed; count unchanged.
  - Empty: write performed, read ignored (no fall-through pop); count becomes 1.
  - Full, either mode: pop then store; both pointers advance, count stays DEPTH, overrun not set.
- Overrun stays set until flush, disabled mode or reset.
- Mode change between 01 and 10 preserves contents; it only affects the next full-write decision.
- Watermark above DEPTH means fifo_watermark never asserts.

Test Plan:
- Reset mid-traffic: hold write for 5 cycles, assert reset asynchronously between edges -> outputs immediately show count 0, empty 1, overrun 0, data_rd 0.
- Oldest-saved fill, DEPTH=8: write 0x10..0x19 (10 writes) -> count 8, full 1, overrun 1. Then 8 reads return 0x10..0x17; empty 1; overrun stays 1 until a flush pulse clears it.
- Stream overwrite, DEPTH=8: write 0x00..0x0B (12 writes) -> count 8, overrun 1. Reads return 0x04..0x0B.
- Pointer wrap and simultaneous access: DEPTH=8, watermark=3.
  - 6 writes, then 6 reads, then 4 writes to cross the wrap.
  - Data stays in order; fifo_watermark rises exactly when count reaches 3.
  - Read+write in the same cycle at count 4 keeps count 4.
- Boundary strobes: read while empty -> no change, empty stays 1. Read+write while empty -> count 1 and data_rd = data_wr on the next cycle. Read+write while full in mode 01 -> count 8, overrun 0.
- Disabled/flush precedence: with count 5, set fifo_mode=00 for one cycle while write=1 -> count 0. Back in mode 01, flush+write in the same cycle -> count 0.

Source files
------------

// File: rtl/adxl362_sample_fifo_if.sv
// ============================================================================
// Module      : adxl362_sample_fifo_if
// Description : Control, data and status bundle of the ADXL362 sample FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adxl362_sample_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9
);
  logic [1:0]            fifo_mode_i;
  logic                  flush_i;
  logic                  write_i;
  logic [DATA_WIDTH-1:0] data_wr_i;
  logic                  read_i;
  logic [ADDR_WIDTH:0]   watermark_i;
  logic [DATA_WIDTH-1:0] data_rd_o;
  logic [ADDR_WIDTH:0]   fifo_count_o;
  logic                  fifo_empty_o;
  logic                  fifo_full_o;
  logic                  fifo_watermark_o;
  logic                  fifo_overrun_o;

  modport master (
    output fifo_mode_i, flush_i, write_i, data_wr_i, read_i, watermark_i,
    input  data_rd_o, fifo_count_o, fifo_empty_o, fifo_full_o,
           fifo_watermark_o, fifo_overrun_o
  );

  modport slave (
    input  fifo_mode_i, flush_i, write_i, data_wr_i, read_i, watermark_i,
    output data_rd_o, fifo_count_o, fifo_empty_o, fifo_full_o,
           fifo_watermark_o, fifo_overrun_o
  );
endinterface

`default_nettype wire

// File: rtl/adxl362_sample_fifo.sv
// ============================================================================
// Module      : adxl362_sample_fifo
// Description : Show-ahead sample FIFO with ADXL362 disabled/oldest/stream modes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adxl362_sample_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  wire logic             clk,
  input  wire logic             rst,
  adxl362_sample_fifo_if.slave  bus
);

  localparam logic [1:0]          c_MODE_STREAM = 2'b10;
  localparam logic [1:0]          c_MODE_OLDEST = 2'b01;
  localparam logic [ADDR_WIDTH:0] c_DEPTH       = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic                  overrun_q, overrun_d;

  logic w_active;
  logic w_empty;
  logic w_full;
  logic w_do_wr;
  logic w_rd_adv;
  logic w_full_wr;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_DEPTH);

  always_comb begin
    w_active  = 1'b0;
    w_do_wr   = 1'b0;
    w_rd_adv  = 1'b0;
    w_full_wr = 1'b0;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;

    w_active = !bus.flush_i &&
               ((bus.fifo_mode_i == c_MODE_OLDEST) || (bus.fifo_mode_i == c_MODE_STREAM));

    if (!w_active) begin
      rd_ptr_d  = '0;
      wr_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      // A full write without a pop overruns; stream mode then evicts the oldest entry.
      w_full_wr = bus.write_i && w_full && !bus.read_i;
      w_do_wr   = bus.write_i && (!w_full_wr || (bus.fifo_mode_i == c_MODE_STREAM));
      w_rd_adv  = (bus.read_i && !w_empty) || (w_full_wr && w_do_wr);

      if (w_do_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (w_rd_adv) rd_ptr_d = rd_ptr_q + 1'b1;
      if (w_do_wr && !w_rd_adv)      count_d = count_q + 1'b1;
      else if (w_rd_adv && !w_do_wr) count_d = count_q - 1'b1;
      if (w_full_wr) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage carries no reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_do_wr) mem_q[wr_ptr_q] <= bus.data_wr_i;
  end

  assign bus.data_rd_o        = w_empty ? '0 : mem_q[rd_ptr_q];
  assign bus.fifo_count_o     = count_q;
  assign bus.fifo_empty_o     = w_empty;
  assign bus.fifo_full_o      = w_full;
  assign bus.fifo_watermark_o = (bus.watermark_i != '0) && (count_q >= bus.watermark_i);
  assign bus.fifo_overrun_o   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_adxl362_sample_fifo.sv
// ============================================================================
// Module      : tb_adxl362_sample_fifo
// Description : Directed plus random checks of the sample FIFO against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_adxl362_sample_fifo;

  localparam int c_DW    = 8;
  localparam int c_AW    = 3;
  localparam int c_DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adxl362_sample_fifo_if #(.DATA_WIDTH(c_DW), .ADDR_WIDTH(c_AW)) bus ();

  adxl362_sample_fifo #(
    .DATA_WIDTH (c_DW),
    .DEPTH      (c_DEPTH),
    .ADDR_WIDTH (c_AW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Reference state: contents oldest-first, plus the sticky overrun flag.
  logic [c_DW-1:0] m_q[$];
  logic            m_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    logic [1:0] md;
    int         sz;
    md = bus.fifo_mode_i;
    sz = m_q.size();
    if (bus.flush_i || md == 2'b00 || md == 2'b11) begin
      m_q.delete();
      m_ovr = 1'b0;
    end else if (bus.read_i && bus.write_i && sz == c_DEPTH) begin
      void'(m_q.pop_front());
      m_q.push_back(bus.data_wr_i);
    end else begin
      if (bus.write_i) begin
        if (sz < c_DEPTH) m_q.push_back(bus.data_wr_i);
        else begin
          m_ovr = 1'b1;
          if (md == 2'b10) begin
            void'(m_q.pop_front());
            m_q.push_back(bus.data_wr_i);
          end
        end
      end
      if (bus.read_i && sz > 0) void'(m_q.pop_front());
    end
  endtask

  task automatic compare_all(input string tag);
    int wm;
    int sz;
    wm = int'(bus.watermark_i);
    sz = m_q.size();
    chk({tag, ".count"}, 32'(bus.fifo_count_o), 32'(sz));
    chk({tag, ".empty"}, 32'(bus.fifo_empty_o), 32'(sz == 0));
    chk({tag, ".full"},  32'(bus.fifo_full_o),  32'(sz == c_DEPTH));
    chk({tag, ".wmark"}, 32'(bus.fifo_watermark_o), 32'(wm != 0 && sz >= wm));
    chk({tag, ".ovr"},   32'(bus.fifo_overrun_o), 32'(m_ovr));
    chk({tag, ".data"},  32'(bus.data_rd_o), (sz == 0) ? 32'd0 : 32'(m_q[0]));
  endtask

  // One clock: inputs held across the edge, model advanced, outputs sampled 1ns later.
  task automatic cyc(input string tag, input logic [1:0] md, input logic fl,
                     input logic w, input logic r, input logic [c_DW-1:0] d);
    bus.fifo_mode_i = md;
    bus.flush_i     = fl;
    bus.write_i     = w;
    bus.read_i      = r;
    bus.data_wr_i   = d;
    @(posedge clk);
    model_edge();
    #1;
    compare_all(tag);
  endtask

  initial begin
    bus.fifo_mode_i = 2'b01;
    bus.flush_i     = 1'b0;
    bus.write_i     = 1'b0;
    bus.read_i      = 1'b0;
    bus.data_wr_i   = '0;
    bus.watermark_i = '0;

    // Reset state
    #12;
    chk("rst.count", 32'(bus.fifo_count_o), 32'd0);
    chk("rst.empty", 32'(bus.fifo_empty_o), 32'd1);
    chk("rst.ovr",   32'(bus.fifo_overrun_o), 32'd0);
    chk("rst.data",  32'(bus.data_rd_o), 32'd0);
    rst = 1'b0;

    // Asynchronous reset in the middle of a write burst
    for (int i = 0; i < 5; i++) cyc("burst", 2'b01, 1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
    #2 rst = 1'b1;
    #1;
    m_q.delete();
    m_ovr = 1'b0;
    chk("arst.count", 32'(bus.fifo_count_o), 32'd0);
    chk("arst.empty", 32'(bus.fifo_empty_o), 32'd1);
    chk("arst.ovr",   32'(bus.fifo_overrun_o), 32'd0);
    chk("arst.data",  32'(bus.data_rd_o), 32'd0);
    rst = 1'b0;

    // Oldest-saved fill past full
    for (int i = 0; i < 10; i++) cyc("ofill", 2'b01, 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    chk("ofill.cnt8", 32'(bus.fifo_count_o), 32'd8);
    chk("ofill.ovr1", 32'(bus.fifo_overrun_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("oread.val", 32'(bus.data_rd_o), 32'(8'h10 + i));
      cyc("oread", 2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
    end
    chk("oread.empty", 32'(bus.fifo_empty_o), 32'd1);
    chk("oread.ovr1",  32'(bus.fifo_overrun_o), 32'd1);
    cyc("oflush", 2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("oflush.ovr0", 32'(bus.fifo_overrun_o), 32'd0);

    // Stream overwrite
    for (int i = 0; i < 12; i++) cyc("sfill", 2'b10, 1'b0, 1'b1, 1'b0, 8'(i));
    chk("sfill.ovr1", 32'(bus.fifo_overrun_o), 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("sread.val", 32'(bus.data_rd_o), 32'(4 + i));
      cyc("sread", 2'b10, 1'b0, 1'b0, 1'b1, 8'h00);
    end

    // Pointer wrap with watermark 3
    cyc("wflush", 2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
    bus.watermark_i = 4'd3;
    for (int i = 0; i < 6; i++) cyc("wwr", 2'b01, 1'b0, 1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 6; i++) cyc("wrd", 2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 4; i++) begin
      cyc("wwrap", 2'b01, 1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
      chk("wwrap.wm", 32'(bus.fifo_watermark_o), 32'(i >= 2));
    end
    cyc("wrw", 2'b01, 1'b0, 1'b1, 1'b1, 8'h5A);
    chk("wrw.cnt4", 32'(bus.fifo_count_o), 32'd4);
    chk("wrw.head", 32'(bus.data_rd_o), 32'h51);

    // Boundary strobes
    cyc("bflush", 2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
    cyc("brd_empty", 2'b01, 1'b0, 1'b0, 1'b1, 8'h00);
    cyc("brw_empty", 2'b01, 1'b0, 1'b1, 1'b1, 8'hA5);
    chk("brw_empty.cnt", 32'(bus.fifo_count_o), 32'd1);
    chk("brw_empty.dat", 32'(bus.data_rd_o), 32'hA5);
    for (int i = 0; i < 7; i++) cyc("bfill", 2'b01, 1'b0, 1'b1, 1'b0, 8'(8'hB0 + i));
    cyc("brw_full", 2'b01, 1'b0, 1'b1, 1'b1, 8'hC3);
    chk("brw_full.cnt", 32'(bus.fifo_count_o), 32'd8);
    chk("brw_full.ovr", 32'(bus.fifo_overrun_o), 32'd0);

    // Disabled and flush precedence over write
    cyc("pflush", 2'b01, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) cyc("pfill", 2'b01, 1'b0, 1'b1, 1'b0, 8'(8'h60 + i));
    cyc("pdis", 2'b00, 1'b0, 1'b1, 1'b0, 8'h66);
    chk("pdis.cnt0", 32'(bus.fifo_count_o), 32'd0);
    for (int i = 0; i < 5; i++) cyc("pfill2", 2'b01, 1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
    cyc("pflw", 2'b01, 1'b1, 1'b1, 1'b0, 8'h77);
    chk("pflw.cnt0", 32'(bus.fifo_count_o), 32'd0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      logic [1:0] md;
      int unsigned sel;
      sel = $urandom_range(0, 39);
      md  = (sel == 0) ? 2'b00 : (sel == 1) ? 2'b11 : (sel < 21) ? 2'b01 : 2'b10;
      bus.watermark_i = 4'($urandom_range(0, 10));
      cyc("rnd", md, ($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 6),
          ($urandom_range(0, 9) < 5), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
